// File: rtl/vmem_fill_ctrl_pkg.sv
// rtl/vmem_fill_ctrl_pkg.sv - shared constants and types for the vmem rectangle-fill engine
package vmem_fill_ctrl_pkg;

  localparam int COORD_W           = 8;
  localparam int MAX_COORD_DEFAULT = 239;

  localparam logic [2:0] REG_P0     = 3'd0;
  localparam logic [2:0] REG_P1     = 3'd1;
  localparam logic [2:0] REG_COLOR  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] max_c);
    return (v > max_c) ? max_c : v;
  endfunction

endpackage

// File: rtl/vmem_fill_ctrl_fill_cursor.sv
// rtl/vmem_fill_ctrl_fill_cursor.sv - raster x/y cursor over a latched rectangle
module vmem_fill_ctrl_fill_cursor
  import vmem_fill_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  logic [COORD_W-1:0] x0_q, x1_q, y1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      cx   <= '0;
      cy   <= '0;
    end else if (load) begin
      x0_q <= x0;
      x1_q <= x1;
      y1_q <= y1;
      cx   <= x0;
      cy   <= y0;
    end else if (en) begin
      if (cx == x1_q) begin
        cx <= x0_q;
        cy <= cy + COORD_W'(1);
      end else begin
        cx <= cx + COORD_W'(1);
      end
    end
  end

  assign last = (cx == x1_q) && (cy == y1_q);

endmodule

// File: rtl/vmem_fill_ctrl.sv
// rtl/vmem_fill_ctrl.sv - rectangle-fill engine, register file and vmem write-port arbiter
module vmem_fill_ctrl
  import vmem_fill_ctrl_pkg::*;
#(
  parameter int MAX_COORD  = MAX_COORD_DEFAULT,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [15:0]           cpu_wdata_i,
  input  logic                  reg_we_i,
  input  logic [2:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  vmem_we_o,
  output logic [ADDR_WIDTH-1:0] vmem_addr_o,
  output logic [15:0]           vmem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX_COORD);

  state_t             state;
  logic [15:0]        p0, p1, color;
  logic [16:0]        count;
  logic               done_sticky;
  logic [31:0]        rdata_next;
  logic [COORD_W-1:0] cx, cy, x0c, y0c, x1c, y1c;
  logic               last, ctrl_wr, start, abort, clr_done, load, degenerate, grant;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata_i[31:16];

  assign ctrl_wr  = reg_we_i && (reg_addr_i == REG_CTRL);
  assign start    = ctrl_wr && reg_wdata_i[CTRL_START];
  assign abort    = ctrl_wr && reg_wdata_i[CTRL_ABORT];
  assign clr_done = ctrl_wr && reg_wdata_i[CTRL_CLR_DONE];

  assign x0c = clamp_coord(p0[7:0],  MAX_C);
  assign y0c = clamp_coord(p0[15:8], MAX_C);
  assign x1c = clamp_coord(p1[7:0],  MAX_C);
  assign y1c = clamp_coord(p1[15:8], MAX_C);

  // ABORT in the same write suppresses START even from IDLE
  assign load       = (state == ST_IDLE) && start && !abort;
  assign degenerate = (x0c > x1c) || (y0c > y1c);
  assign grant      = (state == ST_FILL) && !cpu_we_i;

  vmem_fill_ctrl_fill_cursor u_cursor (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .load  (load),
    .en    (grant),
    .x0    (x0c),
    .y0    (y0c),
    .x1    (x1c),
    .y1    (y1c),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  always_comb begin
    rdata_next = '0;
    case (reg_addr_i)
      REG_P0:     rdata_next[15:0] = p0;
      REG_P1:     rdata_next[15:0] = p1;
      REG_COLOR:  rdata_next[15:0] = color;
      REG_STATUS: begin
        rdata_next[STAT_BUSY] = (state == ST_FILL);
        rdata_next[STAT_DONE] = done_sticky;
      end
      REG_COUNT:  rdata_next[16:0] = count;
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      p0          <= '0;
      p1          <= '0;
      color       <= '0;
      count       <= '0;
      done_sticky <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      reg_rdata_o <= rdata_next;

      if (reg_we_i && (state != ST_FILL)) begin
        case (reg_addr_i)
          REG_P0:    p0    <= reg_wdata_i[15:0];
          REG_P1:    p1    <= reg_wdata_i[15:0];
          REG_COLOR: color <= reg_wdata_i[15:0];
          default:   ;
        endcase
      end

      // completion sets the sticky bit even against a simultaneous CLR_DONE
      if (clr_done)          done_sticky <= 1'b0;
      if (state == ST_DONE)  done_sticky <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (load) begin
            count       <= '0;
            done_sticky <= 1'b0;
            state       <= degenerate ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (grant) count <= count + 17'd1;
          if (abort)              state <= ST_IDLE;
          else if (grant && last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    vmem_we_o    = rst_ni && (cpu_we_i || (state == ST_FILL));
    vmem_addr_o  = cpu_we_i ? cpu_addr_i  : ADDR_WIDTH'({cy, cx});
    vmem_wdata_o = cpu_we_i ? cpu_wdata_i : color;
  end

  assign busy_o = (state == ST_FILL);
  assign done_o = (state == ST_DONE);

endmodule
